// File: rtl/mem_tag_responder_pkg.sv
// ---------------------------------------------------------------------------
// sys_defs: definitions shared by the memory tag responder and its users.
//   XLEN                 processor address width in bits
//   NUM_MEM_TAGS         number of usable tags (tags 1..15; 0 means "none")
//   MEM_LATENCY_DEFAULT  default acceptance-to-backing-store latency (cycles)
//   bus_command_t        BUS_NONE / BUS_LOAD / BUS_STORE (value 3 is illegal)
//   is_mem_cmd()         true for the two commands that start a transaction
// ---------------------------------------------------------------------------
package sys_defs;

    localparam int XLEN                = 32;
    localparam int NUM_MEM_TAGS        = 15;
    localparam int MEM_LATENCY_DEFAULT = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    function automatic logic is_mem_cmd(input logic [1:0] cmd);
        return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
    endfunction

endpackage

// File: rtl/mem_tag_responder_if.sv
// ---------------------------------------------------------------------------
// mem_tag_responder_if: processor-side memory bus.
//   proc2mem_command   2   BUS_NONE / BUS_LOAD / BUS_STORE
//   proc2mem_addr      XLEN byte address (bits [2:0] ignored by the responder)
//   proc2mem_data      64  store data
//   mem_busy           1   forces rejection in the current cycle
//   mem2proc_response  4   combinational accept tag (0 = rejected)
//   mem2proc_tag       4   registered load-return tag (0 = nothing returned)
//   mem2proc_data      64  load-return data, 0 when no tag is returned
// master = processor / environment, slave = responder.
// ---------------------------------------------------------------------------
interface mem_tag_responder_if;
    import sys_defs::*;

    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic            mem_busy;
    logic [3:0]      mem2proc_response;
    logic [3:0]      mem2proc_tag;
    logic [63:0]     mem2proc_data;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data, mem_busy,
        input  mem2proc_response, mem2proc_tag, mem2proc_data
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data, mem_busy,
        output mem2proc_response, mem2proc_tag, mem2proc_data
    );

endinterface

// File: rtl/mem_tag_responder_alloc.sv
// ---------------------------------------------------------------------------
// mem_tag_alloc: lowest-free tag selector.
//   busy      in   NUM_MEM_TAGS  bit k set = tag k outstanding (k = 1..15)
//   free_tag  out  4             lowest-numbered free tag, 0 if none free
//   any_free  out  1             at least one tag is free
// ---------------------------------------------------------------------------
module mem_tag_alloc
    import sys_defs::*;
(
    input  logic [NUM_MEM_TAGS:1] busy,
    output logic [3:0]            free_tag,
    output logic                  any_free
);

    // Scan from the top down so the lowest free tag is the last one written.
    always_comb begin
        free_tag = 4'd0;
        any_free = 1'b0;
        for (int k = NUM_MEM_TAGS; k >= 1; k--) begin
            if (!busy[k]) begin
                free_tag = 4'(k);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_tag_responder.sv
// ---------------------------------------------------------------------------
// mem_tag_responder: tagged memory responder with a fixed-latency delay line
// in front of a synchronous single-port backing store.
//   Parameters
//     MEM_LATENCY    1..12, cycles from acceptance to backing-store access
//     MEM_ADDR_BITS  log2 of the number of 64-bit words in the backing store
//   Ports
//     clock          sole clock, rising edge
//     reset          asynchronous, active-low
//     bus            processor bus (slave modport of mem_tag_responder_if)
//     sram_addr      backing-store word address (0 when idle)
//     sram_rd_en     read strobe; data arrives on sram_rdata next cycle
//     sram_wr_en     write strobe (never together with sram_rd_en)
//     sram_wdata     write data
//     sram_rdata     read data, valid the cycle after sram_rd_en
// ---------------------------------------------------------------------------
module mem_tag_responder
    import sys_defs::*;
#(
    parameter int MEM_LATENCY   = MEM_LATENCY_DEFAULT,
    parameter int MEM_ADDR_BITS = 13
) (
    input  logic                     clock,
    input  logic                     reset,
    mem_tag_responder_if.slave       bus,
    output logic [MEM_ADDR_BITS-1:0] sram_addr,
    output logic                     sram_rd_en,
    output logic                     sram_wr_en,
    output logic [63:0]              sram_wdata,
    input  logic [63:0]              sram_rdata
);

    localparam int LAST = MEM_LATENCY - 1;

    logic [NUM_MEM_TAGS:1]    busy;
    logic [NUM_MEM_TAGS:1]    busy_nxt;
    logic [3:0]               free_tag;
    logic                     any_free;
    logic                     accept;
    logic [MEM_ADDR_BITS-1:0] word_addr;
    logic                     mature_load;
    logic                     mature_store;
    logic [3:0]               ret_tag;

    // One delay-line stage per cycle of latency; the last stage is the one
    // that touches the backing store.
    logic                     vld_p  [MEM_LATENCY];
    logic [1:0]               cmd_p  [MEM_LATENCY];
    logic [3:0]               tag_p  [MEM_LATENCY];
    logic [MEM_ADDR_BITS-1:0] addr_p [MEM_LATENCY];
    logic [63:0]              data_p [MEM_LATENCY];

    // Byte offset and bits above the store size are dropped (address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.proc2mem_addr[XLEN-1:MEM_ADDR_BITS+3],
                                bus.proc2mem_addr[2:0]};
    assign word_addr = bus.proc2mem_addr[MEM_ADDR_BITS+2:3];

    mem_tag_alloc u_alloc (
        .busy     (busy),
        .free_tag (free_tag),
        .any_free (any_free)
    );

    // Including reset here keeps the response at 0 while reset is held.
    assign accept = reset && !bus.mem_busy && any_free
                 && is_mem_cmd(bus.proc2mem_command);
    assign bus.mem2proc_response = accept ? free_tag : 4'd0;

    // ---- stage 0 .. LAST: delay line ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < MEM_LATENCY; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else begin
            vld_p[0] <= accept;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // Payload only has meaning alongside its valid bit, so it is not reset.
    always_ff @(posedge clock) begin
        cmd_p[0]  <= bus.proc2mem_command;
        tag_p[0]  <= free_tag;
        addr_p[0] <= word_addr;
        data_p[0] <= bus.proc2mem_data;
        for (int k = 1; k < MEM_LATENCY; k++) begin
            cmd_p[k]  <= cmd_p[k-1];
            tag_p[k]  <= tag_p[k-1];
            addr_p[k] <= addr_p[k-1];
            data_p[k] <= data_p[k-1];
        end
    end

    // ---- stage LAST: backing-store access ----
    assign mature_load  = vld_p[LAST] && (cmd_p[LAST] == BUS_LOAD);
    assign mature_store = vld_p[LAST] && (cmd_p[LAST] == BUS_STORE);

    assign sram_rd_en = mature_load;
    assign sram_wr_en = mature_store;
    assign sram_addr  = vld_p[LAST] ? addr_p[LAST] : '0;
    assign sram_wdata = mature_store ? data_p[LAST] : 64'd0;

    // ---- return stage: tag registered, data straight from the store ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ret_tag <= 4'd0;
            busy    <= '0;
        end else begin
            ret_tag <= mature_load ? tag_p[LAST] : 4'd0;
            busy    <= busy_nxt;
        end
    end

    // Frees are computed from the registered bitmap, so a tag released this
    // cycle only becomes visible to the allocator next cycle.
    always_comb begin
        busy_nxt = busy;
        if (accept) begin
            busy_nxt[free_tag] = 1'b1;
        end
        if (ret_tag != 4'd0) begin
            busy_nxt[ret_tag] = 1'b0;
        end
        if (mature_store) begin
            busy_nxt[tag_p[LAST]] = 1'b0;
        end
    end

    assign bus.mem2proc_tag  = ret_tag;
    assign bus.mem2proc_data = (ret_tag != 4'd0) ? sram_rdata : 64'd0;

endmodule

// File: tb/tb_mem_tag_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_tag_responder: directed bench for two responder instances
// (latency 4 and latency 12) sharing clock and reset, each with its own
// behavioural backing store. Accepted requests push expected strobes and
// load returns into per-instance queues; a negedge monitor pops and checks.
// ---------------------------------------------------------------------------
module tb_mem_tag_responder;
    import sys_defs::*;

    typedef struct {
        int          due;
        logic [1:0]  cmd;
        logic [3:0]  tag;
        logic [12:0] addr;
        logic [63:0] data;
    } sq_t;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } rq_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_assert;
    int   n_fail;
    bit   mon_en;
    int   lat [2];

    mem_tag_responder_if b4 ();
    mem_tag_responder_if b12 ();

    logic [12:0] sram_addr  [2];
    logic        sram_rd_en [2];
    logic        sram_wr_en [2];
    logic [63:0] sram_wdata [2];
    logic [63:0] sram_rdata [2];
    logic [3:0]  resp [2];
    logic [3:0]  rtag [2];
    logic [63:0] rdat [2];

    assign resp[0] = b4.mem2proc_response;
    assign resp[1] = b12.mem2proc_response;
    assign rtag[0] = b4.mem2proc_tag;
    assign rtag[1] = b12.mem2proc_tag;
    assign rdat[0] = b4.mem2proc_data;
    assign rdat[1] = b12.mem2proc_data;

    mem_tag_responder #(.MEM_LATENCY(4), .MEM_ADDR_BITS(13)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .bus        (b4),
        .sram_addr  (sram_addr[0]),
        .sram_rd_en (sram_rd_en[0]),
        .sram_wr_en (sram_wr_en[0]),
        .sram_wdata (sram_wdata[0]),
        .sram_rdata (sram_rdata[0])
    );

    mem_tag_responder #(.MEM_LATENCY(12), .MEM_ADDR_BITS(13)) dut12 (
        .clock      (clock),
        .reset      (reset),
        .bus        (b12),
        .sram_addr  (sram_addr[1]),
        .sram_rd_en (sram_rd_en[1]),
        .sram_wr_en (sram_wr_en[1]),
        .sram_wdata (sram_wdata[1]),
        .sram_rdata (sram_rdata[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Unwritten words read back a pattern derived from their address.
    function automatic logic [63:0] pat(input logic [12:0] w);
        return {16'hFACE, 3'b000, w, 16'hBEEF, 3'b000, w};
    endfunction

    // Behavioural backing stores.
    logic [63:0] smem   [2][8192];
    bit          swr    [2][8192];
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (sram_wr_en[i]) begin
                smem[i][sram_addr[i]] <= sram_wdata[i];
                swr[i][sram_addr[i]]  <= 1'b1;
            end
            if (sram_rd_en[i]) begin
                sram_rdata[i] <= swr[i][sram_addr[i]] ? smem[i][sram_addr[i]]
                                                       : pat(sram_addr[i]);
            end
        end
    end

    // Bench's own view of memory contents in acceptance order.
    logic [63:0] shadow [2][8192];
    bit          sh_v   [2][8192];

    sq_t       sq [2][$];
    rq_t       rq [2][$];
    bit [15:0] outst [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input int i, input logic [1:0] cmd, input logic [31:0] a,
                         input logic [63:0] d, input logic busy);
        if (i == 0) begin
            b4.proc2mem_command = cmd;
            b4.proc2mem_addr    = a;
            b4.proc2mem_data    = d;
            b4.mem_busy         = busy;
        end else begin
            b12.proc2mem_command = cmd;
            b12.proc2mem_addr    = a;
            b12.proc2mem_data    = d;
            b12.mem_busy         = busy;
        end
    endtask

    // One bus cycle: drive, check the combinational response, book expectations.
    task automatic step(input int i, input logic [1:0] cmd, input logic [31:0] a,
                        input logic [63:0] d, input logic busy, input logic [3:0] exp_resp);
        logic [12:0] w;
        w = a[15:3];
        drive(i, cmd, a, d, busy);
        @(negedge clock);
        chk($sformatf("dut%0d.response", i), 64'(resp[i]), 64'(exp_resp));
        if (resp[i] != 4'd0) begin
            chk($sformatf("dut%0d.tag_unique", i), 64'(outst[i][resp[i]]), 64'd0);
            outst[i][resp[i]] = 1'b1;
        end
        if (exp_resp != 4'd0) begin
            sq[i].push_back('{due: cyc + lat[i], cmd: cmd, tag: exp_resp, addr: w, data: d});
            if (cmd == BUS_LOAD) begin
                rq[i].push_back('{due: cyc + lat[i] + 1, tag: exp_resp,
                                  data: sh_v[i][w] ? shadow[i][w] : pat(w)});
            end else begin
                shadow[i][w] = d;
                sh_v[i][w]   = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        drive(i, BUS_NONE, 32'd0, 64'd0, 1'b0);
    endtask

    task automatic idle(input int i, input int n);
        repeat (n) step(i, BUS_NONE, 32'd0, 64'd0, 1'b0, 4'd0);
    endtask

    // Monitor: strobes and load returns against the scoreboard every cycle.
    always @(negedge clock) begin : monitor
        sq_t s;
        rq_t r;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (sq[i].size() != 0 && sq[i][0].due == cyc) begin
                    s = sq[i].pop_front();
                    chk($sformatf("dut%0d.sram_rd_en", i), 64'(sram_rd_en[i]), 64'(s.cmd == BUS_LOAD));
                    chk($sformatf("dut%0d.sram_wr_en", i), 64'(sram_wr_en[i]), 64'(s.cmd == BUS_STORE));
                    chk($sformatf("dut%0d.sram_addr", i), 64'(sram_addr[i]), 64'(s.addr));
                    if (s.cmd == BUS_STORE) begin
                        chk($sformatf("dut%0d.sram_wdata", i), sram_wdata[i], s.data);
                        outst[i][s.tag] = 1'b0;
                    end
                end else begin
                    chk($sformatf("dut%0d.idle_rd_en", i), 64'(sram_rd_en[i]), 64'd0);
                    chk($sformatf("dut%0d.idle_wr_en", i), 64'(sram_wr_en[i]), 64'd0);
                    chk($sformatf("dut%0d.idle_addr", i), 64'(sram_addr[i]), 64'd0);
                end
                if (rq[i].size() != 0 && rq[i][0].due == cyc) begin
                    r = rq[i].pop_front();
                    chk($sformatf("dut%0d.mem2proc_tag", i), 64'(rtag[i]), 64'(r.tag));
                    chk($sformatf("dut%0d.mem2proc_data", i), rdat[i], r.data);
                    outst[i][r.tag] = 1'b0;
                end else begin
                    chk($sformatf("dut%0d.no_tag", i), 64'(rtag[i]), 64'd0);
                    chk($sformatf("dut%0d.no_data", i), rdat[i], 64'd0);
                end
            end
        end
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        mon_en   = 1'b0;
        lat[0]   = 4;
        lat[1]   = 12;
        outst[0] = '0;
        outst[1] = '0;
        reset    = 1'b1;
        drive(0, BUS_NONE, 32'd0, 64'd0, 1'b0);
        drive(1, BUS_NONE, 32'd0, 64'd0, 1'b0);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        // Reset held: a LOAD must be rejected and outputs stay 0.
        drive(0, BUS_LOAD, 32'h40, 64'd0, 1'b0);
        @(negedge clock);
        chk("reset.response", 64'(resp[0]), 64'd0);
        chk("reset.tag", 64'(rtag[0]), 64'd0);
        @(posedge clock);
        #1;
        drive(0, BUS_NONE, 32'd0, 64'd0, 1'b0);
        reset = 1'b1;
        idle(0, 2);

        // Single LOAD: tag 1, read word 8 four cycles later, return one after.
        step(0, BUS_LOAD, 32'h40, 64'd0, 1'b0, 4'd1);
        idle(0, 7);

        // Back-to-back LOADs, including a wrapped address with byte offset.
        step(0, BUS_LOAD, 32'h100, 64'd0, 1'b0, 4'd1);
        step(0, BUS_LOAD, 32'h108, 64'd0, 1'b0, 4'd2);
        step(0, BUS_LOAD, 32'h0001_004F, 64'd0, 1'b0, 4'd3);
        idle(0, 7);

        // STORE then LOAD to the same word: read sees the written data.
        step(0, BUS_STORE, 32'h40, 64'hDEAD, 1'b0, 4'd1);
        step(0, BUS_LOAD, 32'h40, 64'd0, 1'b0, 4'd2);
        idle(0, 7);

        // Rejections: mem_busy and the illegal command encoding.
        step(0, BUS_LOAD, 32'h80, 64'd0, 1'b1, 4'd0);
        step(0, 2'd3, 32'h80, 64'h55, 1'b0, 4'd0);
        step(0, BUS_STORE, 32'h88, 64'h77, 1'b1, 4'd0);
        idle(0, 6);

        // Reset mid-flight: three LOADs accepted, then everything dropped.
        step(0, BUS_LOAD, 32'h200, 64'd0, 1'b0, 4'd1);
        step(0, BUS_LOAD, 32'h208, 64'd0, 1'b0, 4'd2);
        drive(0, BUS_LOAD, 32'h210, 64'd0, 1'b0);
        @(negedge clock);
        chk("dut0.response", 64'(resp[0]), 64'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset.response", 64'(resp[0]), 64'd0);
        chk("midreset.tag", 64'(rtag[0]), 64'd0);
        chk("midreset.data", rdat[0], 64'd0);
        sq[0].delete();
        rq[0].delete();
        outst[0] = '0;
        @(posedge clock);
        #1;
        drive(0, BUS_NONE, 32'd0, 64'd0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(0, 7);
        step(0, BUS_LOAD, 32'h300, 64'd0, 1'b0, 4'd1);
        idle(0, 7);

        // Latency 12, LOAD every cycle: 1..13, then 14, then reuse from 1.
        for (int k = 0; k <= 20; k++) begin
            step(1, BUS_LOAD, 32'h1000 + 32'(k * 8), 64'd0, 1'b0,
                 (k < 13) ? 4'(k + 1) : (k == 13) ? 4'd14 : 4'(k - 13));
        end
        idle(1, 16);

        chk("dut0.pending", 64'(sq[0].size() + rq[0].size()), 64'd0);
        chk("dut1.pending", 64'(sq[1].size() + rq[1].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
